led_mode_ctrl: RTL

Button-driven sequencer for the 4-LED bank on the PL. It debounces one push key, steps a mode FSM through OFF/RUN/BOUNCE/BLINK/COUNT, and generates the step tick from the 50 MHz PL clock at a selectable rate. It drives the LED pins directly and exports MODE/STEP for status and debug.

---
 rtl/led_mode_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - debounced mode key, mode FSM, step tick and LED pattern generator
module led_mode_ctrl #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int STEP_CYCLES     = CLOCK_FREQ / 2,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_N,
  input  logic [1:0] SPEED,
  input  logic       PAUSE,
  output logic [3:0] LED,
  output logic [2:0] MODE,
  output logic       STEP
);

  localparam logic [2:0]  M_OFF    = 3'd0;
  localparam logic [2:0]  M_RUN    = 3'd1;
  localparam logic [2:0]  M_BOUNCE = 3'd2;
  localparam logic [2:0]  M_BLINK  = 3'd3;
  localparam logic [2:0]  M_COUNT  = 3'd4;
  localparam logic [31:0] STEP_W   = 32'(STEP_CYCLES);
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);

  logic        key_meta, key_sync, key_stable;
  logic [31:0] db_cnt;
  logic        press;
  logic [2:0]  mode, mode_next;
  logic        mode_valid;
  logic [31:0] tick_cnt, period;
  logic        run, wrap;
  logic [3:0]  led_q, init_pat, next_pat;
  logic        dir_q, next_dir;
  logic        step_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= KEY_N;
      key_sync <= key_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_cnt     <= '0;
      key_stable <= 1'b1;
    end else if (key_sync == key_stable) begin
      db_cnt <= '0;
    end else if (db_cnt >= DB_LAST) begin
      key_stable <= key_sync;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  // Press fires in the cycle the stable level is about to drop; releases are ignored.
  assign press = key_stable & ~key_sync & (db_cnt >= DB_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mode <= M_OFF;
    else     mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      M_OFF:    if (press) mode_next = M_RUN;
      M_RUN:    if (press) mode_next = M_BOUNCE;
      M_BOUNCE: if (press) mode_next = M_BLINK;
      M_BLINK:  if (press) mode_next = M_COUNT;
      M_COUNT:  if (press) mode_next = M_OFF;
      default:  mode_next = M_OFF;
    endcase
  end

  always_comb begin
    mode_valid = (mode <= M_COUNT);
    period     = STEP_W >> SPEED;
    if (period == 32'd0) period = 32'd1;
    run  = mode_valid && (mode != M_OFF) && !PAUSE;
    // >= keeps the overrun to one cycle when SPEED shortens the period mid-count.
    wrap = run && (tick_cnt >= period - 32'd1);

    case (mode_next)
      M_RUN, M_BOUNCE: init_pat = 4'b0001;
      M_BLINK:         init_pat = 4'b1111;
      default:         init_pat = 4'b0000;
    endcase

    next_pat = led_q;
    next_dir = dir_q;
    case (mode)
      M_RUN:   next_pat = {led_q[2:0], led_q[3]};
      M_BOUNCE: begin
        if (!dir_q) begin
          next_pat = led_q[3] ? 4'b0100 : {led_q[2:0], 1'b0};
          next_dir = led_q[3];
        end else begin
          next_pat = led_q[0] ? 4'b0010 : {1'b0, led_q[3:1]};
          next_dir = ~led_q[0];
        end
      end
      M_BLINK: next_pat = ~led_q;
      M_COUNT: next_pat = led_q + 4'd1;
      default: next_pat = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       tick_cnt <= '0;
    else if (press || wrap) tick_cnt <= '0;
    else if (run)  tick_cnt <= tick_cnt + 32'd1;
  end

  // A press on a wrap cycle wins: initial pattern loads and no STEP is emitted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q  <= 4'b0000;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= wrap & ~press;
      if (press || !mode_valid) begin
        led_q <= init_pat;
        dir_q <= 1'b0;
      end else if (wrap) begin
        led_q <= next_pat;
        dir_q <= next_dir;
      end
    end
  end

  assign LED  = led_q;
  assign MODE = mode;
  assign STEP = step_q;

endmodule
